// File: rtl/mem_stage_pbus.sv
// ============================================================================
// mem_stage_pbus -- RV32I MEM stage driving a BUS_BYTES-wide req/ack memory
// port; optional misalignment trap under MEM_ALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_pbus #(
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             wd_i,
  input  logic                   wreg_i,
  input  logic [31:0]            wdata_i,
  input  logic [31:0]            mem_w_data_i,
  input  logic [7:0]             mem_op_type_i,
  input  logic                   mem_ack,
  input  logic [8*BUS_BYTES-1:0] memctrl_data_in,
  output logic                   mem_req,
  output logic                   mem_r_w,
  output logic [ADDR_W-1:0]      mem_req_addr,
  output logic [8*BUS_BYTES-1:0] mem_req_data,
  output logic [BUS_BYTES-1:0]   mem_be,
  output logic                   mem_stall_req,
  output logic [4:0]             wd_o,
  output logic                   wreg_o,
  output logic [31:0]            wdata_o,
  output logic                   load_done,
  output logic                   misalign_o
);

  localparam logic [7:0] c_op_lb  = 8'h01;
  localparam logic [7:0] c_op_lh  = 8'h02;
  localparam logic [7:0] c_op_lw  = 8'h03;
  localparam logic [7:0] c_op_lbu = 8'h04;
  localparam logic [7:0] c_op_lhu = 8'h05;
  localparam logic [7:0] c_op_sb  = 8'h06;
  localparam logic [7:0] c_op_sh  = 8'h07;
  localparam logic [7:0] c_op_sw  = 8'h08;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_mem_req;
  logic                     r_mem_r_w;
  logic [ADDR_W-1:0]        r_addr;
  logic [8*BUS_BYTES-1:0]   r_data;
  logic [BUS_BYTES-1:0]     r_be;
  logic                     r_load_done;
  logic [2:0]               r_beat;
  logic [31:0]              r_asm;

  logic                     w_is_load;
  logic                     w_is_store;
  logic                     w_is_mem;
  logic [2:0]               w_size;
  logic [2:0]               w_beats;
  logic                     w_last;
  logic [2:0]               w_k;
  logic                     w_misaligned;
  logic [ADDR_W-1:0]        w_base;
  logic [ADDR_W-1:0]        w_beat_addr;
  logic [8*BUS_BYTES-1:0]   w_beat_data;
  logic [BUS_BYTES-1:0]     w_beat_be;
  logic [31:0]              w_load_val;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = 3'd1;
    case (mem_op_type_i)
      c_op_lb, c_op_lbu: begin w_is_load  = 1'b1; w_size = 3'd1; end
      c_op_lh, c_op_lhu: begin w_is_load  = 1'b1; w_size = 3'd2; end
      c_op_lw:           begin w_is_load  = 1'b1; w_size = 3'd4; end
      c_op_sb:           begin w_is_store = 1'b1; w_size = 3'd1; end
      c_op_sh:           begin w_is_store = 1'b1; w_size = 3'd2; end
      c_op_sw:           begin w_is_store = 1'b1; w_size = 3'd4; end
      default:           ;
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;
  assign w_beats  = 3'((int'(w_size) + BUS_BYTES - 1) / BUS_BYTES);
  assign w_last   = (r_beat == (w_beats - 3'd1));
  // Beat 0 is loaded from IDLE; later beats are preloaded while the current one is acked.
  assign w_k      = (r_state == S_IDLE) ? 3'd0 : (r_beat + 3'd1);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = w_is_mem &&
                        (((w_size == 3'd2) && wdata_i[0]) ||
                         ((w_size == 3'd4) && (wdata_i[1:0] != 2'b00)));
`else
  assign w_misaligned = 1'b0;
`endif

  generate
    if (ADDR_W <= 32) begin : g_base_narrow
      assign w_base = wdata_i[ADDR_W-1:0];
    end else begin : g_base_wide
      assign w_base = {{(ADDR_W-32){1'b0}}, wdata_i};
    end
  endgenerate

  assign w_beat_addr = w_base + ADDR_W'(32'(w_k) * BUS_BYTES);

  always_comb begin
    w_beat_be   = '0;
    w_beat_data = '0;
    for (int j = 0; j < BUS_BYTES; j++) begin
      if ((int'(w_k) * BUS_BYTES + j) < int'(w_size)) begin
        w_beat_be[j] = 1'b1;
        if (w_is_store)
          w_beat_data[8*j +: 8] = mem_w_data_i[8*(2'(int'(w_k) * BUS_BYTES + j)) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_is_mem) w_state_nxt = w_misaligned ? S_DONE : S_BUSY;
      S_BUSY:  if (mem_ack && r_mem_req && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_r_w   <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_load_done <= 1'b0;
      r_beat      <= 3'd0;
      r_asm       <= 32'd0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_is_mem && !w_misaligned) begin
            r_mem_req <= 1'b1;
            r_mem_r_w <= w_is_store;
            r_addr    <= w_beat_addr;
            r_data    <= w_beat_data;
            r_be      <= w_beat_be;
            r_beat    <= 3'd0;
            r_asm     <= 32'd0;
          end
        end
        S_BUSY: begin
          if (mem_ack && r_mem_req) begin
            for (int j = 0; j < BUS_BYTES; j++) begin
              if (r_be[j])
                r_asm[8*(2'(int'(r_beat) * BUS_BYTES + j)) +: 8] <= memctrl_data_in[8*j +: 8];
            end
            if (w_last) begin
              r_mem_req   <= 1'b0;
              r_load_done <= w_is_load;
            end else begin
              r_beat <= r_beat + 3'd1;
              r_addr <= w_beat_addr;
              r_data <= w_beat_data;
              r_be   <= w_beat_be;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_misalign <= 1'b0;
    else      r_misalign <= (r_state == S_IDLE) && w_misaligned;
  end
  assign misalign_o = r_misalign;
`else
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    case (mem_op_type_i)
      c_op_lb:  w_load_val = {{24{r_asm[7]}}, r_asm[7:0]};
      c_op_lbu: w_load_val = {24'd0, r_asm[7:0]};
      c_op_lh:  w_load_val = {{16{r_asm[15]}}, r_asm[15:0]};
      c_op_lhu: w_load_val = {16'd0, r_asm[15:0]};
      default:  w_load_val = r_asm;
    endcase
  end

  assign mem_req       = r_mem_req;
  assign mem_r_w       = r_mem_r_w;
  assign mem_req_addr  = r_addr;
  assign mem_req_data  = r_data;
  assign mem_be        = r_be;
  assign load_done     = r_load_done;
  assign mem_stall_req = rst && w_is_mem && (r_state != S_DONE);
  assign wd_o          = rst ? wd_i : 5'd0;
  assign wreg_o        = rst && wreg_i && !w_misaligned;
  assign wdata_o       = !rst ? 32'd0 : (w_is_load ? w_load_val : wdata_i);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_pbus.sv
// ============================================================================
// tb_mem_stage_pbus -- bench for mem_stage_pbus at BUS_BYTES 1, 2 and 4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_pbus;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_LB  = 8'h01;
  localparam logic [7:0] OP_LH  = 8'h02;
  localparam logic [7:0] OP_LW  = 8'h03;
  localparam logic [7:0] OP_LBU = 8'h04;
  localparam logic [7:0] OP_LHU = 8'h05;
  localparam logic [7:0] OP_SB  = 8'h06;
  localparam logic [7:0] OP_SH  = 8'h07;
  localparam logic [7:0] OP_SW  = 8'h08;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mwd_i;
  logic [7:0]  op [3];
  logic        ack [3];
  logic [31:0] din [3];
  logic        req [3];
  logic        rw [3];
  logic [31:0] raddr [3];
  logic [31:0] rdata [3];
  logic [3:0]  be [3];
  logic        stall [3];
  logic [4:0]  wd_o [3];
  logic        wreg_o [3];
  logic [31:0] wdata_o [3];
  logic        ld [3];
  logic        mis_o [3];

  logic [7:0]  mem [3][1024];
  int          ncmp = 0;
  int          nerr = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int BB = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      logic [8*BB-1:0] w_rdata;
      logic [BB-1:0]   w_be;
      mem_stage_pbus #(.ADDR_W(32), .BUS_BYTES(BB)) u_dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_w_data_i(mwd_i), .mem_op_type_i(op[g]), .mem_ack(ack[g]),
        .memctrl_data_in(din[g][8*BB-1:0]), .mem_req(req[g]), .mem_r_w(rw[g]),
        .mem_req_addr(raddr[g]), .mem_req_data(w_rdata), .mem_be(w_be),
        .mem_stall_req(stall[g]), .wd_o(wd_o[g]), .wreg_o(wreg_o[g]),
        .wdata_o(wdata_o[g]), .load_done(ld[g]), .misalign_o(mis_o[g])
      );
      assign rdata[g] = 32'(w_rdata);
      assign be[g]    = 4'(w_be);
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bbv(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic string tg(input string s, input int i);
    return $sformatf("%s[bb%0d]", s, bbv(i));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string s);
    for (int i = 0; i < 3; i++) begin
      chk(tg({s, "_req"}, i),    32'(req[i]),    32'd0);
      chk(tg({s, "_stall"}, i),  32'(stall[i]),  32'd0);
      chk(tg({s, "_wd"}, i),     32'(wd_o[i]),   32'd0);
      chk(tg({s, "_wreg"}, i),   32'(wreg_o[i]), 32'd0);
      chk(tg({s, "_wdata"}, i),  wdata_o[i],     32'd0);
      chk(tg({s, "_ld"}, i),     32'(ld[i]),     32'd0);
      chk(tg({s, "_mis"}, i),    32'(mis_o[i]),  32'd0);
    end
  endtask

  // Reference model: one pipeline op, served by a memory controller with
  // per-beat wait states; w0 >= 0 fixes the waits on beat 0.
  task automatic do_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] d,
                       input int w0, input int wmax);
    int          n, k, bb, idx;
    bit          isld, isst, ismem, mis, alld;
    int          waits [3][4];
    int          expb [3], expst [3], scnt [3], nb [3], wl [3];
    bit          fin [3];
    logic [31:0] ev [3];
    logic [31:0] raw, ebe, edata;
    logic [4:0]  wdv;
    isld  = o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    isst  = o inside {OP_SB, OP_SH, OP_SW};
    ismem = isld || isst;
    n     = (o == OP_LB || o == OP_LBU || o == OP_SB) ? 1 : ((o == OP_LW || o == OP_SW) ? 4 : 2);
    mis   = CHK && ismem && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
    wdv   = 5'($urandom);
    for (int i = 0; i < 3; i++) begin
      expb[i]  = (ismem && !mis) ? (n + bbv(i) - 1) / bbv(i) : 0;
      expst[i] = !ismem ? 0 : (mis ? 1 : 1 + expb[i]);
      for (int b = 0; b < 4; b++) begin
        waits[i][b] = (b == 0 && w0 >= 0) ? w0 : int'($urandom_range(wmax));
        if (b < expb[i]) expst[i] += waits[i][b];
      end
      raw = 32'd0;
      for (int b = 0; b < n; b++)
        raw |= 32'(mem[i][int'((a + 32'(b)) & 32'h3FF)]) << (8 * b);
      case (o)
        OP_LB:   ev[i] = {{24{raw[7]}}, raw[7:0]};
        OP_LBU:  ev[i] = {24'd0, raw[7:0]};
        OP_LH:   ev[i] = {{16{raw[15]}}, raw[15:0]};
        OP_LHU:  ev[i] = {16'd0, raw[15:0]};
        OP_LW:   ev[i] = raw;
        default: ev[i] = a;
      endcase
      scnt[i] = 0; nb[i] = 0; fin[i] = 1'b0; wl[i] = waits[i][0];
    end
    @(negedge clk);
    wdata_i = a; mwd_i = d; wd_i = wdv; wreg_i = 1'b1;
    for (int i = 0; i < 3; i++) op[i] = o;
    for (int c = 0; c < 100; c++) begin
      #1;
      alld = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!fin[i]) begin
          bb = bbv(i);
          if (req[i]) begin
            if (nb[i] >= expb[i]) begin
              chk(tg("beat_count_overrun", i), 32'(nb[i]), 32'(expb[i] - 1));
              ack[i] = 1'b1;
            end else begin
              k = nb[i];
              ebe = 32'd0; edata = 32'd0;
              for (int j = 0; j < bb; j++) begin
                idx = k * bb + j;
                if (idx < n) begin
                  ebe[j] = 1'b1;
                  edata[8*j +: 8] = 8'(d >> (8 * idx));
                end
              end
              chk(tg("beat_addr", i), raddr[i], a + 32'(k * bb));
              chk(tg("beat_be", i), 32'(be[i]), ebe);
              chk(tg("beat_rw", i), 32'(rw[i]), 32'(isst));
              if (isst) chk(tg("beat_wdata", i), rdata[i], edata);
              din[i] = $urandom;
              if (wl[i] > 0) begin
                ack[i] = 1'b0;
                wl[i]--;
              end else begin
                ack[i] = 1'b1;
                for (int j = 0; j < bb; j++) begin
                  idx = k * bb + j;
                  if (idx < n) begin
                    din[i][8*j +: 8] = mem[i][int'((a + 32'(idx)) & 32'h3FF)];
                    if (isst) mem[i][int'((a + 32'(idx)) & 32'h3FF)] = edata[8*j +: 8];
                  end
                end
                nb[i]++;
                if (nb[i] < expb[i]) wl[i] = waits[i][nb[i]];
              end
            end
          end else begin
            ack[i] = 1'($urandom);
            din[i] = $urandom;
          end
          if (stall[i]) scnt[i]++;
          else begin
            fin[i] = 1'b1;
            chk(tg("stall_cycles", i), 32'(scnt[i]), 32'(expst[i]));
            chk(tg("beats", i), 32'(nb[i]), 32'(expb[i]));
            if (!mis) chk(tg("wdata_o", i), wdata_o[i], ev[i]);
            chk(tg("wreg_o", i), 32'(wreg_o[i]), 32'(!mis));
            chk(tg("wd_o", i), 32'(wd_o[i]), 32'(wdv));
            chk(tg("load_done", i), 32'(ld[i]), 32'(isld && !mis));
            chk(tg("misalign_o", i), 32'(mis_o[i]), 32'(mis));
            op[i] = OP_ADD;
          end
          if (!fin[i]) alld = 1'b0;
        end
      end
      if (alld) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (!fin[i]) begin
        chk(tg("timeout_done", i), 32'd0, 32'd1);
        op[i] = OP_ADD;
      end
      ack[i] = 1'b0;
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk(tg("after_ld", i), 32'(ld[i]), 32'd0);
      chk(tg("after_req", i), 32'(req[i]), 32'd0);
      chk(tg("after_mis", i), 32'(mis_o[i]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [10];
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADD, 8'h20};
    for (int i = 0; i < 3; i++)
      for (int m = 0; m < 1024; m++) mem[i][m] = 8'($urandom);
    rst = 1'b1; wd_i = 5'h1F; wreg_i = 1'b1; wdata_i = 32'hCAFE_0100; mwd_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin op[i] = OP_LW; ack[i] = 1'b0; din[i] = 32'd0; end
    #2 rst = 1'b0;
    #2;
    chk_all_zero("reset");
    for (int i = 0; i < 3; i++) begin
      chk(tg("reset_addr", i), raddr[i], 32'd0);
      chk(tg("reset_be", i), 32'(be[i]), 32'd0);
      chk(tg("reset_rw", i), 32'(rw[i]), 32'd0);
      chk(tg("reset_wdata", i), rdata[i], 32'd0);
      op[i] = OP_ADD;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Word load, ack every cycle.
    for (int i = 0; i < 3; i++) begin
      mem[i][32'h100] = 8'h78; mem[i][32'h101] = 8'h56;
      mem[i][32'h102] = 8'h34; mem[i][32'h103] = 8'h12;
      mem[i][32'h201] = 8'h80;
    end
    do_op(OP_LW, 32'h100, 32'd0, 0, 0);
    do_op(OP_LB, 32'h201, 32'd0, 0, 0);
    do_op(OP_LBU, 32'h201, 32'd0, 0, 0);
    do_op(OP_SW, 32'h040, 32'hDEAD_BEEF, 0, 0);
    do_op(OP_SH, 32'h040, 32'h1234_BEEF, 0, 0);
    do_op(OP_LW, 32'h040, 32'd0, -1, 2);
    do_op(OP_SH, 32'h300, 32'h0000_A5C3, 3, 0);
    do_op(OP_LHU, 32'h300, 32'd0, -1, 1);

    // Reset in the middle of an LW (beat 2 on the byte-wide port).
    @(negedge clk);
    wdata_i = 32'h100; wd_i = 5'd7; wreg_i = 1'b1;
    for (int i = 0; i < 3; i++) begin op[i] = OP_LW; ack[i] = 1'b1; end
    repeat (3) @(negedge clk);
    #1;
    chk("midreset_pre_req[bb1]", 32'(req[0]), 32'd1);
    chk("midreset_pre_addr[bb1]", raddr[0], 32'h102);
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 3; i++) begin op[i] = OP_ADD; ack[i] = 1'b0; end
    @(negedge clk);
    rst = 1'b1;
    do_op(OP_ADD, 32'h0000_1234, 32'd0, 0, 0);

    // Misaligned word: trapped when alignment checking is built in, else normal beats.
    do_op(OP_LW, 32'h102, 32'd0, 0, 0);
    do_op(OP_SH, 32'h105, 32'h0000_7E81, -1, 1);

    for (int t = 0; t < 24; t++)
      do_op(ops[$urandom_range(9)], 32'($urandom_range(1000)), $urandom, -1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_pbus.md
# mem_stage_pbus

Parametrised successor to the byte-serial MEM stage of the pipelined RV32I core. It sits between EX/MEM and MEM/WB and passes non-memory results straight through. It runs each load or store as a sequence of beats on a memory-controller port `BUS_BYTES` wide, where each beat is an explicit req/ack handshake that tolerates wait states. It stalls the pipeline until the access completes, then presents sign- or zero-extended load data.

## Interface
- `ADDR_W`, default 32, address width.
- `BUS_BYTES`, default 1, memory port width in bytes; legal values 1, 2, 4.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `wd_i`  in  `RegAddrBus`  destination register.
- `wreg_i`  in  1  register write enable.
- `wdata_i`  in  `RegBus`  ALU result; this is the effective address for memory ops.
- `mem_w_data_i`  in  `RegBus`  store data.
- `mem_op_type_i`  in  `AluSelBus`  op select (`LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW`/other).
- `mem_ack`  in  1  controller accepts the current beat; read data is valid in the same cycle.
- `memctrl_data_in`  in  8·BUS_BYTES  read data; lane j holds byte j.
- `mem_req`  out  1  beat request.
- `mem_r_w`  out  1  0 = read, 1 = write.
- `mem_req_addr`  out  ADDR_W  beat address.
- `mem_req_data`  out  8·BUS_BYTES  write data.
- `mem_be`  out  BUS_BYTES  lane byte enables.
- `mem_stall_req`  out  1  stall request to the pipeline controller.
- `wd_o`  out  `RegAddrBus`  destination register.
- `wreg_o`  out  1  register write enable.
- `wdata_o`  out  `RegBus`  result to MEM/WB.
- `load_done`  out  1  one-cycle pulse when load data is presented.
- `misalign_o`  out  1  misaligned-access pulse; see Configuration.

## Operation
- **Access size and beat count.** Access size N is 1 (B/BU), 2 (H/HU) or 4 (W). Beats = ceil(N/BUS_BYTES).
- **Beat k addressing.**
  - `mem_req_addr` = `wdata_i` + k·BUS_BYTES.
  - Lane j carries access byte k·BUS_BYTES+j.
  - `mem_be` lane j = 1 iff k·BUS_BYTES+j < N.
  - Write-data lanes beyond N drive 0.
- **State machine.**
  - IDLE: on a memory op (registered), load beat 0 and assert `mem_req`, then go to BUSY.
  - BUSY: hold all request outputs stable while `mem_ack`=0.
    - On `mem_ack`=1: capture enabled read lanes into a 32-bit assembly register at byte offset k·BUS_BYTES.
    - If this was not the last beat, advance to beat k+1 with `mem_req` kept high (no gap cycle).
    - On the last beat, drop `mem_req` and go to DONE.
  - DONE: one cycle, then IDLE.
- **`mem_stall_req`.** Combinational. High when a memory op is present and the state is not DONE. Low for non-memory ops.
- **`wdata_o` for loads.** Presented from the assembly register, extended per op:
  - LB: sign-extend from bit 7.
  - LBU: zero-extend from byte.
  - LH: sign-extend from bit 15.
  - LHU: zero-extend from halfword.
  - LW: as assembled.
- **`wdata_o` otherwise.** `wdata_i` for stores and non-memory ops.
- **`wd_o`/`wreg_o`.** Always follow `wd_i`/`wreg_i` combinationally, except when forced low on a misaligned access (see Configuration).
- **`load_done`.** High for the DONE cycle of loads only.
- **Input stability.** Inputs are held stable by the pipeline while stall is high. The block does not re-latch the op mid-access.
- **Reset.**
  - Registered outputs reset to 0: `mem_req`, `mem_r_w`, `mem_req_addr`, `mem_req_data`, `mem_be`, `load_done`, `misalign_o`.
  - Combinational outputs (`wd_o`, `wreg_o`, `wdata_o`) are forced to 0 while reset is low.
  - `mem_stall_req` is forced to 0 while reset is low.
  - State goes to IDLE and the assembly register to 0.
  - Reset mid-access abandons the access immediately; `mem_req` falls asynchronously. No partial-write recovery is provided.

## Timing
- Access with ack in every cycle: `mem_stall_req` high for beats+1 cycles, DONE follows, and the pipeline advances at the end of DONE.
  - Example: LW with BUS_BYTES=1 stalls 5 cycles.
  - Example: LW with BUS_BYTES=4 stalls 2 cycles.
- Each ack-low cycle adds exactly one cycle.
- A back-to-back memory op entering in the cycle after DONE starts from IDLE with no penalty.
- `mem_ack` while `mem_req`=0 is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN`, defined:
  - A halfword access with addr[0]≠0, or a word access with addr[1:0]≠0, issues no beats.
  - The block goes IDLE→DONE: stall is high for one cycle.
  - `misalign_o` pulses high in DONE.
  - `wreg_o` is forced to 0 for that op.
  - `load_done` stays 0.
- `MEM_ALIGN_CHECK_EN`, undefined:
  - Misaligned accesses proceed as normal byte-addressed beats.
  - `misalign_o` is tied to 0.

## Test plan
- BUS_BYTES=1, LW addr 0x100, read bytes 0x78,0x56,0x34,0x12, ack every cycle -> addresses 0x100–0x103, stall 5 cycles, `wdata_o`=0x12345678, one `load_done` pulse.
- BUS_BYTES=2, LB then LBU at 0x201, lane0=0x80 -> 1 beat, `mem_be`=2'b01, `wdata_o` 0xFFFFFF80 then 0x00000080.
- BUS_BYTES=4, SW 0xDEADBEEF at 0x40, then SH 0xBEEF -> single beats with `mem_be` 4'b1111 then 4'b0011, `mem_r_w`=1, `mem_req_data` 0xDEADBEEF then 0x0000BEEF.
- BUS_BYTES=1, SH with `mem_ack` low for 3 cycles on beat 0 -> addr/data/`mem_req` held steady, stall lasts 6 cycles, byte 0 written before byte 1.
- Assert `rst` low during beat 2 of an LW -> `mem_req`, stall and outputs go 0 immediately; after release, ADD result passes through with stall 0.
- With `MEM_ALIGN_CHECK_EN`, LW at 0x102 -> no `mem_req`, stall 1 cycle, `misalign_o` pulse, `wreg_o`=0.
